// File: rtl/color_pkg.sv
// Shared definitions for the colour register-file write path.
package color_pkg;

   // Handshake initiator states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_RELEASE,
      ST_DONE,
      ST_ERR
   } state_t;

   // Nibbles per colour and their register-file addresses
   localparam int NIBBLES = 6;

   localparam logic [3:0] ADDR_RH = 4'd0;
   localparam logic [3:0] ADDR_RL = 4'd1;
   localparam logic [3:0] ADDR_GH = 4'd2;
   localparam logic [3:0] ADDR_GL = 4'd3;
   localparam logic [3:0] ADDR_BH = 4'd4;
   localparam logic [3:0] ADDR_BL = 4'd5;

   // Selects the nibble of an {R,G,B} word that lives at a given address
   function automatic logic [3:0] nibble_of(input logic [23:0] rgb, input logic [3:0] addr);
      logic [3:0] nib;
      nib = 4'h0;
      case (addr)
         ADDR_RH: nib = rgb[23:20];
         ADDR_RL: nib = rgb[19:16];
         ADDR_GH: nib = rgb[15:12];
         ADDR_GL: nib = rgb[11:8];
         ADDR_BH: nib = rgb[7:4];
         ADDR_BL: nib = rgb[3:0];
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/hs_timeout_counter.sv
// Per-phase timeout counter for four-phase handshake initiators.
// expired is raised during the TIMEOUT-th enabled cycle after a clear, so the
// owning FSM leaves the phase after exactly TIMEOUT cycles in it.
module hs_timeout_counter #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   assign expired = enable && (count >= W'(TIMEOUT - 1));

   // Count enabled cycles since the last clear, saturating once expired
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/color_regfile_writer.sv
// Serialises a 24-bit RGB colour into six 4-bit register-file writes.
// Handshake: valid rises with stable channel/address/data, the regfile raises
// ack, valid falls, the regfile drops ack, and only then may the next nibble
// raise valid. Any phase lasting TIMEOUT cycles aborts the transfer with err.
module color_regfile_writer
   import color_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [1:0]  req_channel,
   input  logic [23:0] req_rgb,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [1:0]  channel,
   output logic [3:0]  address,
   output logic [3:0]  data,
   output logic        valid,
   input  logic        ack
);

   state_t      state;
   state_t      state_next;
   logic [3:0]  idx;
   logic [23:0] rgb_q;
   logic [1:0]  ch_q;
   logic        expired;
   logic        timer_clear;
   logic        timer_enable;

   // Timer restarts on every state change and runs only in handshake phases
   assign timer_clear  = (state_next != state);
   assign timer_enable = (state == ST_SEND) || (state == ST_RELEASE);

   hs_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (expired)
   );

   // Next-state logic; timeout wins over ack in the same cycle
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (req) state_next = ST_SEND;
         end
         ST_SEND: begin
            if (expired)  state_next = ST_ERR;
            else if (ack) state_next = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (expired) begin
               state_next = ST_ERR;
            end else if (!ack) begin
               state_next = (idx == 4'(NIBBLES - 1)) ? ST_DONE : ST_SEND;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         ST_ERR:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register, request capture and nibble index advance
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         rgb_q <= '0;
         ch_q  <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && req) begin
            rgb_q <= req_rgb;
            ch_q  <= req_channel;
            idx   <= '0;
         end else if (state == ST_RELEASE && state_next == ST_SEND) begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign ready   = (state == ST_IDLE);
   assign done    = (state == ST_DONE);
   assign err     = (state == ST_ERR);
   assign valid   = (state == ST_SEND);
   assign channel = ch_q;
   assign address = idx;
   assign data    = nibble_of(rgb_q, idx);

endmodule

// File: doc/color_regfile_writer.md
# color_regfile_writer

Initiator for the colour register-file write port. Accepts a 24-bit RGB value and a 2-bit channel index from a controller (UART command decoder, default-palette loader) and serialises it into six 4-bit writes over the `channel`/`address`/`data`/`valid`/`ack` interface consumed by `color_regfile`. Each write uses a four-phase handshake guarded by a timeout.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in one handshake phase before abort; legal range 2..65535.
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `req`  in  1  write request; sampled only while `ready`=1
- `req_channel`  in  2  target channel 0..3
- `req_rgb`  in  24  colour, {R[7:0], G[7:0], B[7:0]}
- `ready`  out  1  idle and able to accept `req`
- `done`  out  1  one-cycle pulse: all six nibbles acknowledged
- `err`  out  1  one-cycle pulse: transfer aborted on timeout
- `channel`  out  2  channel under write, held for the whole transfer
- `address`  out  4  nibble address 0..5
- `data`  out  4  nibble payload
- `valid`  out  1  write strobe toward regfile
- `ack`  in  1  regfile acknowledge

## Operation
- Reset values: `ready`=1, `done`=0, `err`=0, `valid`=0, `channel`=0, `address`=0, `data`=0; state IDLE; timeout counter 0.
- Address map: 0 = R[7:4], 1 = R[3:0], 2 = G[7:4], 3 = G[3:0], 4 = B[7:4], 5 = B[3:0]. Addresses 6..15 are never driven.
- States: IDLE, SEND (`valid`=1, waiting for `ack`=1), RELEASE (`valid`=0, waiting for `ack`=0), DONE, ERR.
- IDLE: on `req`=1, latch `req_channel` and `req_rgb` into internal registers and go to SEND with nibble index 0. While `ack`=1 in IDLE, the block ignores it.
- SEND: `address`/`data`/`channel` stay stable while `valid`=1. `ack`=1 goes to RELEASE.
- RELEASE: `ack`=0 with index<5 increments the index and returns to SEND. `ack`=0 with index=5 goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1 for one cycle, `valid`=0, then IDLE. Nibbles already written are not rolled back.
- Timeout counter is `$clog2(TIMEOUT+1)` bits. It clears on every state entry and increments each cycle in SEND/RELEASE. Reaching `TIMEOUT` in either state goes to ERR, and takes precedence over `ack` in the same cycle.
- `req` outside IDLE is ignored and not queued. `req_*` changes after acceptance do not affect the transfer in flight.
- `rst` mid-transfer: state returns to IDLE and `valid` is 0 on the cycle after the reset edge. `done`/`err` are not pulsed.

## Timing
- Edge 0 samples `req`=1 in IDLE. From cycle 1: `valid`=1, `address`=0, `data`=R[7:4], `ready`=0.
- `ack` sampled high at edge k: `valid`=0 from cycle k+1.
- `ack` sampled low at edge m in RELEASE: next nibble with `valid`=1 from cycle m+1.
- With a regfile acking and releasing in 1 cycle each: 2 cycles per nibble, and `done` 13 cycles after acceptance. `ready`=1 the cycle after `done`.
- `valid` never rises while `ack` is still sampled high.
- Latest `err` occurrence: `TIMEOUT`+1 cycles after entering a stuck phase.

## Structure
- Shared package `color_pkg`:
  - state enum
  - `NIBBLES`=6
  - nibble address constants `ADDR_RH`..`ADDR_BL`, shared with `color_regfile`.
- Sub-module `hs_timeout_counter`: clear/enable inputs, `expired` output, parameterised on `TIMEOUT`. It is reusable by other handshake initiators.
- Nibble mux: `data` = `rgb_q[23-4*idx -: 4]`.

## Test plan
- Basic write: req ch=2, rgb=0x12AB3C, responder acks in 1 cycle -> (address,data) sequence (0,1),(1,2),(2,A),(3,B),(4,3),(5,C), `channel`=2 throughout, `done` at cycle 13.
- Slow responder: ack delayed 5 cycles per phase -> same sequence, data stable while `valid`=1, single `done`, no `err`.
- Timeout: TIMEOUT=8, responder never acks -> `valid` high 8 cycles, `err` pulse, `valid`=0, `ready`=1 next cycle, no `done`.
- Stuck-high ack: ack held at 1 after nibble 2 -> RELEASE times out, `err`; new req afterwards completes normally.
- Busy req and reset: second req (rgb=0xFFFFFF) mid-transfer -> ignored, first colour completes. `rst` asserted at nibble 3 -> `valid`=0 next cycle, all outputs at reset values, no `done`/`err`.
